bus_decoder_nx: RTL and testbench

- Parametrised N-slave interconnect on the picorv32 native memory bus.
- Replaces hand-coded chip-select decoding for RAM, UART and GPIO with per-slave base/mask regions.
- Registered response path; decode-miss error response; per-transaction slave timeout.
- Sits between the picorv32 core and all memory-mapped peripherals.

---
 rtl/bus_decoder_nx_if.sv | 42 ++++
 rtl/bus_decoder_nx.sv | 193 +++++++++++++++++++
 tb/tb_bus_decoder_nx.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_decoder_nx_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_decoder_nx_if
// Brief    : picorv32 native memory bus, core side and N fan-out slave ports.
// Revision : 1.0
// ============================================================================
interface bus_decoder_nx_if #(
    parameter int N_SLAVES = 3
);
    logic                    mem_valid;
    logic                    mem_instr;
    logic [31:0]             mem_addr;
    logic [31:0]             mem_wdata;
    logic [3:0]              mem_wstrb;
    logic                    mem_ready;
    logic [31:0]             mem_rdata;

    logic [N_SLAVES-1:0]     s_valid;
    logic                    s_instr;
    logic [31:0]             s_addr;
    logic [31:0]             s_wdata;
    logic [3:0]              s_wstrb;
    logic [N_SLAVES-1:0]     s_ready;
    logic [32*N_SLAVES-1:0]  s_rdata;

    // Decoder view: accepts core requests, drives the slave fan-out.
    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata,
        output s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        input  s_ready, s_rdata
    );

    // Environment view: core plus slave peripherals.
    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata,
        input  s_valid, s_instr, s_addr, s_wdata, s_wstrb,
        output s_ready, s_rdata
    );
endinterface
`default_nettype wire

// File: rtl/bus_decoder_nx.sv
`default_nettype none
// ============================================================================
// Module   : bus_decoder_nx
// Brief    : base/mask address decoder for N slaves on the picorv32 bus with
//            registered response, decode-miss error and slave timeout.
//            Optional error log enabled by macro BUS_DECODER_ERRLOG_EN.
// Revision : 1.0
// ============================================================================
module bus_decoder_nx #(
    parameter int                     N_SLAVES       = 3,
    parameter logic [32*N_SLAVES-1:0] SLAVE_BASE     = {32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
    parameter logic [32*N_SLAVES-1:0] SLAVE_MASK     = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFF8_0000},
    parameter int                     TIMEOUT_CYCLES = 255,
    parameter logic [31:0]            ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic             clk,
    input  logic             reset,
    bus_decoder_nx_if.slave  bus,
    output logic             bus_err,
    output logic [31:0]      err_addr,
    output logic             err_irq,
    input  logic             err_clr
);
    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]          state_q,   state_d;
    logic [IDX_W-1:0]    idx_q,     idx_d;
    logic                hit_q,     hit_d;
    logic [15:0]         cnt_q,     cnt_d;
    logic [N_SLAVES-1:0] s_valid_q, s_valid_d;
    logic [31:0]         addr_q,    addr_d;
    logic [31:0]         wdata_q,   wdata_d;
    logic [3:0]          wstrb_q,   wstrb_d;
    logic                instr_q,   instr_d;
    logic                ready_q,   ready_d;
    logic [31:0]         rdata_q,   rdata_d;
    logic                err_q,     err_d;

    logic                w_hit;
    logic [IDX_W-1:0]    w_hit_idx;
    logic [15:0]         w_cnt_inc;

    // Descending scan so the lowest matching region overrides higher ones.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((bus.mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hit_d     = hit_q;
        cnt_d     = cnt_q;
        s_valid_d = s_valid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        instr_d   = instr_q;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        w_cnt_inc = cnt_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (bus.mem_valid) begin
                    addr_d  = bus.mem_addr;
                    wdata_d = bus.mem_wdata;
                    wstrb_d = bus.mem_wstrb;
                    instr_d = bus.mem_instr;
                    idx_d   = w_hit_idx;
                    hit_d   = w_hit;
                    cnt_d   = '0;
                    for (int i = 0; i < N_SLAVES; i++) begin
                        s_valid_d[i] = w_hit && (w_hit_idx == IDX_W'(i));
                    end
                    state_d = S_ACTIVE;
                end
            end
            // A miss spends one ACTIVE cycle with no slave selected, giving it
            // the same two-cycle response latency as a zero-wait slave.
            S_ACTIVE: begin
                cnt_d = w_cnt_inc;
                if (!hit_q) begin
                    rdata_d = ERR_RDATA;
                    err_d   = 1'b1;
                    ready_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (bus.s_ready[idx_q]) begin
                    rdata_d   = bus.s_rdata[32*idx_q +: 32];
                    s_valid_d = '0;
                    ready_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_DONE;
                end else if (w_cnt_inc == 16'(TIMEOUT_CYCLES)) begin
                    rdata_d   = ERR_RDATA;
                    s_valid_d = '0;
                    err_d     = 1'b1;
                    ready_d   = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                s_valid_d = '0;
                cnt_d     = '0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            cnt_q     <= '0;
            s_valid_q <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            instr_q   <= 1'b0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            cnt_q     <= cnt_d;
            s_valid_q <= s_valid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            instr_q   <= instr_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    assign bus.mem_ready = ready_q;
    assign bus.mem_rdata = rdata_q;
    assign bus.s_valid   = s_valid_q;
    assign bus.s_instr   = instr_q;
    assign bus.s_addr    = addr_q;
    assign bus.s_wdata   = wdata_q;
    assign bus.s_wstrb   = wstrb_q;
    assign bus_err       = err_q;

`ifdef BUS_DECODER_ERRLOG_EN
    logic [31:0] err_addr_q;
    logic        err_irq_q;

    // Captured on entry to the error DONE cycle; a new error beats err_clr.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_addr_q <= '0;
            err_irq_q  <= 1'b0;
        end else if (err_d) begin
            err_addr_q <= addr_q;
            err_irq_q  <= 1'b1;
        end else if (err_clr) begin
            err_irq_q  <= 1'b0;
        end
    end

    assign err_addr = err_addr_q;
    assign err_irq  = err_irq_q;
`else
    logic w_unused_err_clr;

    assign w_unused_err_clr = err_clr;
    assign err_addr         = '0;
    assign err_irq          = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_bus_decoder_nx.sv
`default_nettype none
// Bench for bus_decoder_nx: directed vector table, reset and err_clr sequences,
// then randomized transactions checked against a transaction-level model.
module tb_bus_decoder_nx;
    localparam int          NS   = 3;
    localparam int          TMO  = 8;
    localparam logic [31:0] ERRV = 32'hDEAD_BEEF;
`ifdef BUS_DECODER_ERRLOG_EN
    localparam bit ERRLOG = 1'b1;
`else
    localparam bit ERRLOG = 1'b0;
`endif
    localparam logic [31:0] BASES [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000};
    localparam logic [31:0] MASKS [NS] = '{32'hFFF8_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0};

    typedef struct {
        int          idx;        // -1 = decode miss
        bit          err;
        int          latency;    // cycles from mem_valid sample to mem_ready
        int          sv_cycles;  // cycles s_valid is high
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
        int          lat;        // slave wait cycles, -1 = never ready
        logic [31:0] srd;
        exp_t        e;
    } vec_t;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic        err_clr = 1'b0;
    logic        bus_err;
    logic        err_irq;
    logic [31:0] err_addr;

    int          n_chk = 0;
    int          n_fail = 0;
    int          sl_lat = -1;
    int          wait_cnt = 0;
    bit          noise = 1'b0;
    logic [NS-1:0] rdy;
    logic [31:0] m_ea = '0;
    logic        m_irq = 1'b0;
    vec_t        vecs [11];

    bus_decoder_nx_if #(.N_SLAVES(NS)) bus ();

    bus_decoder_nx #(
        .N_SLAVES       (NS),
        .SLAVE_BASE     ({32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_MASK     ({32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFF8_0000}),
        .TIMEOUT_CYCLES (TMO),
        .ERR_RDATA      (ERRV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .bus_err  (bus_err),
        .err_addr (err_addr),
        .err_irq  (err_irq),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    // Slave responder: selected slave is ready after sl_lat cycles of s_valid;
    // unselected slaves may raise spurious ready when noise is on.
    always @(negedge clk) begin
        rdy = noise ? NS'($urandom) : '0;
        if (bus.s_valid != '0) begin
            if (sl_lat >= 0 && wait_cnt == sl_lat) rdy = rdy | bus.s_valid;
            else                                   rdy = rdy & ~bus.s_valid;
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
        bus.s_ready = rdy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] addr, input int lat, input logic [31:0] srd);
        exp_t e;
        e.idx = -1;
        foreach (BASES[i]) if (e.idx < 0 && (addr & MASKS[i]) == BASES[i]) e.idx = i;
        if (e.idx < 0) begin
            e.err = 1'b1; e.latency = 2; e.sv_cycles = 0; e.rdata = ERRV;
        end else if (lat >= 0 && lat < TMO) begin
            e.err = 1'b0; e.latency = lat + 2; e.sv_cycles = lat + 1; e.rdata = srd;
        end else begin
            e.err = 1'b1; e.latency = TMO + 1; e.sv_cycles = TMO; e.rdata = ERRV;
        end
        return e;
    endfunction

    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic instr, input int lat, input logic [31:0] srd,
                           input exp_t e, input string tag);
        int            lat_seen = 0;
        int            sv_cyc = 0;
        bit            bad_sv = 1'b0;
        bit            bad_err = 1'b0;
        bit            seen = 1'b0;
        logic [NS-1:0] exp_sv;
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        bus.mem_instr = instr;
        for (int i = 0; i < NS; i++) bus.s_rdata[32*i +: 32] = $urandom;
        if (e.idx >= 0) bus.s_rdata[32*e.idx +: 32] = srd;
        sl_lat = lat;
        for (int k = 1; k <= 3*TMO + 20 && !seen; k++) begin
            @(negedge clk);
            exp_sv = '0;
            if (e.idx >= 0 && k <= e.sv_cycles) exp_sv[e.idx] = 1'b1;
            if (bus.s_valid !== exp_sv) bad_sv = 1'b1;
            if (bus.s_valid != '0) sv_cyc++;
            if (k == 1) begin
                chk({tag, "/s_addr"},  bus.s_addr,  addr);
                chk({tag, "/s_wdata"}, bus.s_wdata, wdata);
                chk({tag, "/s_wstrb"}, 32'(bus.s_wstrb), 32'(wstrb));
                chk({tag, "/s_instr"}, 32'(bus.s_instr), 32'(instr));
            end
            if (bus.mem_ready === 1'b1) begin
                seen     = 1'b1;
                lat_seen = k;
                if (e.err) begin
                    m_ea  = addr;
                    m_irq = 1'b1;
                end
                chk({tag, "/mem_rdata"}, bus.mem_rdata, e.rdata);
                chk({tag, "/bus_err"},   32'(bus_err), 32'(e.err));
                chk({tag, "/err_addr"},  err_addr, ERRLOG ? m_ea : 32'h0);
                chk({tag, "/err_irq"},   32'(err_irq), ERRLOG ? 32'(m_irq) : 32'h0);
            end else if (bus_err !== 1'b0) begin
                bad_err = 1'b1;
            end
        end
        chk({tag, "/latency"},      32'(lat_seen), 32'(e.latency));
        chk({tag, "/s_valid_seq"},  32'(bad_sv), 32'h0);
        chk({tag, "/s_valid_cyc"},  32'(sv_cyc), 32'(e.sv_cycles));
        chk({tag, "/err_no_ready"}, 32'(bad_err), 32'h0);
        // Hold mem_valid across the edge that ends the response cycle.
        @(posedge clk);
        #1 bus.mem_valid = 1'b0;
        @(negedge clk);
        chk({tag, "/ready_pulse"}, 32'(bus.mem_ready), 32'h0);
        chk({tag, "/no_reaccept"}, 32'(bus.s_valid), 32'h0);
    endtask

    initial begin
        logic [31:0] edges [5];
        logic [31:0] addr, srd;
        int          lat;
        int          sel;
        bit          bad;
        exp_t        e;

        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        bus.s_rdata   = '0;

        vecs[0]  = '{32'h0000_0100, 32'h0, 4'h0, 1'b0, 1,  32'h1234_5678, '{0,  1'b0, 3, 2, 32'h1234_5678}};
        vecs[1]  = '{32'h1000_0004, 32'h41, 4'b0001, 1'b0, 0, 32'hA5A5_0001, '{1, 1'b0, 2, 1, 32'hA5A5_0001}};
        vecs[2]  = '{32'h3000_0000, 32'h0, 4'h0, 1'b0, 0,  32'h0,         '{-1, 1'b1, 2, 0, ERRV}};
        vecs[3]  = '{32'h2000_0000, 32'h0, 4'h0, 1'b0, -1, 32'h5555_AAAA, '{2,  1'b1, 9, 8, ERRV}};
        vecs[4]  = '{32'h2000_0000, 32'h0, 4'h0, 1'b0, 7,  32'hCAFE_0007, '{2,  1'b0, 9, 8, 32'hCAFE_0007}};
        vecs[5]  = '{32'h0007_FFFC, 32'h0, 4'h0, 1'b0, 2,  32'h0BAD_F00D, '{0,  1'b0, 4, 3, 32'h0BAD_F00D}};
        vecs[6]  = '{32'h0008_0000, 32'h0, 4'h0, 1'b0, 0,  32'h0,         '{-1, 1'b1, 2, 0, ERRV}};
        vecs[7]  = '{32'h1000_0010, 32'h0, 4'h0, 1'b0, 0,  32'h0,         '{-1, 1'b1, 2, 0, ERRV}};
        vecs[8]  = '{32'h1000_000F, 32'h0, 4'h0, 1'b1, 4,  32'h0F0F_1234, '{1,  1'b0, 6, 5, 32'h0F0F_1234}};
        vecs[9]  = '{32'h2000_000C, 32'hFFFF_0000, 4'hF, 1'b0, 8, 32'h7777_7777, '{2, 1'b1, 9, 8, ERRV}};
        vecs[10] = '{32'h2000_000C, 32'h0, 4'h0, 1'b1, 0,  32'h1357_9BDF, '{2,  1'b0, 2, 1, 32'h1357_9BDF}};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst/mem_ready", 32'(bus.mem_ready), 32'h0);
        chk("rst/mem_rdata", bus.mem_rdata, 32'h0);
        chk("rst/s_valid",   32'(bus.s_valid), 32'h0);
        chk("rst/s_addr",    bus.s_addr, 32'h0);
        chk("rst/s_wdata",   bus.s_wdata, 32'h0);
        chk("rst/s_wstrb_instr", {27'h0, bus.s_instr, bus.s_wstrb}, 32'h0);
        chk("rst/bus_err",   32'(bus_err), 32'h0);
        chk("rst/err_log",   err_addr | 32'(err_irq), 32'h0);
        reset = 1'b0;
        noise = 1'b1;

        foreach (vecs[i])
            run_txn(vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].instr,
                    vecs[i].lat, vecs[i].srd, vecs[i].e, $sformatf("vec%0d", i));

        // Sticky error flag, then err_clr pulse
        repeat (3) @(negedge clk);
        chk("irq/sticky",   32'(err_irq), ERRLOG ? 32'(m_irq) : 32'h0);
        chk("irq/err_addr", err_addr, ERRLOG ? m_ea : 32'h0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_irq   = 1'b0;
        chk("irq/cleared", 32'(err_irq), 32'h0);

        // err_clr held across an error: the new error sets the flag
        err_clr = 1'b1;
        run_txn(32'h3000_0000, 32'h0, 4'h0, 1'b0, 0, 32'h0, model(32'h3000_0000, 0, 32'h0), "clr_vs_set");
        err_clr = 1'b0;
        m_irq   = 1'b0;
        chk("clr_vs_set/after", 32'(err_irq), 32'h0);

        // Reset during an ACTIVE slave0 request
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = 32'h0000_0100;
        bus.mem_wstrb = 4'h0;
        sl_lat        = -1;
        @(negedge clk);
        @(negedge clk);
        chk("midrst/active", 32'(bus.s_valid), 32'h1);
        reset         = 1'b1;
        bus.mem_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst/s_valid",   32'(bus.s_valid), 32'h0);
        chk("midrst/mem_ready", 32'(bus.mem_ready), 32'h0);
        chk("midrst/s_addr",    bus.s_addr, 32'h0);
        chk("midrst/err_log",   err_addr | 32'(err_irq) | 32'(bus_err), 32'h0);
        m_ea  = '0;
        m_irq = 1'b0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.mem_ready !== 1'b0 || bus.s_valid !== '0) bad = 1'b1;
        end
        chk("midrst/no_response", 32'(bad), 32'h0);
        run_txn(32'h1000_0000, 32'h0, 4'h0, 1'b0, 1, 32'h2468_ACE0,
                '{1, 1'b0, 3, 2, 32'h2468_ACE0}, "midrst/next");

        // Randomized transactions against the model
        edges = '{32'h0008_0000, 32'h1000_0010, 32'h1FFF_FFFF, 32'h2000_0010, 32'h0007_FFFF};
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0:       addr = $urandom & 32'h0007_FFFF;
                1:       addr = 32'h1000_0000 | ($urandom & 32'hF);
                2:       addr = 32'h2000_0000 | ($urandom & 32'hF);
                3:       addr = $urandom;
                default: addr = edges[$urandom_range(0, 4)];
            endcase
            lat = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 10);
            srd = $urandom;
            e   = model(addr, lat, srd);
            run_txn(addr, $urandom, 4'($urandom), 1'($urandom), lat, srd, e, $sformatf("rnd%0d", t));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
